// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and default widths for the dot-product sequencer.
// State encoding plus lane geometry used by the controller and MAC.
package dot_pkg;

    localparam int DW_IN     = 8;
    localparam int DW_OUT    = 16;
    localparam int ADDR_W    = 4;
    localparam int PARA_DEG  = 2;
    localparam int LANE_W_IN = DW_IN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/dot_product_ctrl_if.sv
// SRAM-side bus of the dot-product sequencer: two read ports,
// one write port and the shared clear strobe.
interface dot_product_ctrl_if
    import dot_pkg::*;
#(
    parameter int Data_Width_In  = DW_IN,
    parameter int Data_Width_Out = DW_OUT,
    parameter int Addr_Width     = ADDR_W,
    parameter int Para_Deg       = PARA_DEG
);
    logic                               Mem_Clear;
    logic                               In_Chip_Select;
    logic                               In_En_Read;
    logic [Addr_Width-1:0]              In_Read_Addr;
    logic [Para_Deg*Data_Width_In-1:0]  In_Read_Data0;
    logic [Para_Deg*Data_Width_In-1:0]  In_Read_Data1;
    logic                               Out_Chip_Select;
    logic                               Out_En_Write;
    logic [Addr_Width-1:0]              Out_Write_Addr;
    logic [Para_Deg*Data_Width_Out-1:0] Out_Write_Data;

    modport master (
        output Mem_Clear, In_Chip_Select, In_En_Read, In_Read_Addr,
        output Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data,
        input  In_Read_Data0, In_Read_Data1
    );

    modport slave (
        input  Mem_Clear, In_Chip_Select, In_En_Read, In_Read_Addr,
        input  Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data,
        output In_Read_Data0, In_Read_Data1
    );
endinterface

// File: rtl/dot_product_ctrl_mac.sv
// Combinational multiply of all lanes and adder tree into one
// partial sum one bit wider than the result word.
module dot_mac_lanes
    import dot_pkg::*;
#(
    parameter int Data_Width_In  = DW_IN,
    parameter int Data_Width_Out = DW_OUT,
    parameter int Para_Deg       = PARA_DEG
) (
    input  logic [Para_Deg*Data_Width_In-1:0] i_a,
    input  logic [Para_Deg*Data_Width_In-1:0] i_b,
    output logic [Data_Width_Out:0]           o_sum
);
    localparam int PW = 2 * Data_Width_In;

    logic [PW-1:0]         w_prod [Para_Deg];
    logic [Data_Width_Out:0] w_sum;

    for (genvar k = 0; k < Para_Deg; k++) begin : g_lane
        logic [PW-1:0] w_a;
        logic [PW-1:0] w_b;
        assign w_a = PW'(i_a[k*Data_Width_In +: Data_Width_In]);
        assign w_b = PW'(i_b[k*Data_Width_In +: Data_Width_In]);
        assign w_prod[k] = w_a * w_b;
    end

    // Sum the per-lane products.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < Para_Deg; k++) begin
            w_sum = w_sum + (Data_Width_Out+1)'(w_prod[k]);
        end
    end

    assign o_sum = w_sum;
endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: streams Len words from two SRAMs, accumulates
// lane products, writes the scalar result and pulses Done.
module dot_product_ctrl
    import dot_pkg::*;
#(
    parameter int Data_Width_In  = DW_IN,
    parameter int Data_Width_Out = DW_OUT,
    parameter int Addr_Width     = ADDR_W,
    parameter int Ram_Depth      = 1 << Addr_Width,
    parameter int Para_Deg       = PARA_DEG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Start,
    input  logic                      Clear_Req,
    input  logic [Addr_Width-1:0]     Base_Addr,
    input  logic [Addr_Width:0]       Len,
    input  logic [Addr_Width-1:0]     Out_Addr,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Overflow,
    output logic [Data_Width_Out-1:0] Result,
    dot_product_ctrl_if.master        mem
);
    localparam logic [Addr_Width:0] RAM_LEN = (Addr_Width+1)'(Ram_Depth);

    state_t                     r_state;
    state_t                     w_next;
    logic [Addr_Width-1:0]      r_addr;
    logic [Addr_Width:0]        r_left;
    logic [Addr_Width-1:0]      r_oaddr;
    logic                       r_vld;
    logic [Data_Width_Out-1:0]  r_acc;
    logic                       r_ovf;
    logic [Data_Width_Out-1:0]  r_result;
    logic [Addr_Width:0]        w_len;
    logic [Data_Width_Out:0]    w_part;
    logic [Data_Width_Out+1:0]  w_acc_sum;
    logic                       w_go;

    assign w_len     = (Len > RAM_LEN) ? RAM_LEN : Len;
    assign w_go      = (r_state == S_IDLE) && !Clear_Req && Start;
    assign w_acc_sum = (Data_Width_Out+2)'(r_acc)
                     + (Data_Width_Out+2)'(w_part);

    dot_mac_lanes #(
        .Data_Width_In  (Data_Width_In),
        .Data_Width_Out (Data_Width_Out),
        .Para_Deg       (Para_Deg)
    ) u_mac (
        .i_a   (mem.In_Read_Data0),
        .i_b   (mem.In_Read_Data1),
        .o_sum (w_part)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state selection; clear wins over start in IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (Clear_Req)       w_next = S_CLEAR;
                else if (Start)      w_next = (w_len == '0) ? S_WRITE : S_READ;
            end
            S_CLEAR: w_next = S_IDLE;
            S_READ:  if (r_left == (Addr_Width+1)'(1)) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; everything idles at zero.
    always_comb begin
        Busy                = (r_state != S_IDLE);
        Done                = 1'b0;
        mem.Mem_Clear       = 1'b0;
        mem.In_Chip_Select  = 1'b0;
        mem.In_En_Read      = 1'b0;
        mem.In_Read_Addr    = '0;
        mem.Out_Chip_Select = 1'b0;
        mem.Out_En_Write    = 1'b0;
        mem.Out_Write_Addr  = '0;
        mem.Out_Write_Data  = '0;
        unique case (r_state)
            S_CLEAR: mem.Mem_Clear = 1'b1;
            S_READ: begin
                mem.In_Chip_Select = 1'b1;
                mem.In_En_Read     = 1'b1;
                mem.In_Read_Addr   = r_addr;
            end
            S_WRITE: begin
                mem.Out_Chip_Select = 1'b1;
                mem.Out_En_Write    = 1'b1;
                mem.Out_Write_Addr  = r_oaddr;
                mem.Out_Write_Data[Data_Width_Out-1:0] = r_acc;
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, address walk, accumulation and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_left   <= '0;
            r_oaddr  <= '0;
            r_vld    <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            r_vld <= (r_state == S_READ);
            if (w_go) begin
                r_addr  <= Base_Addr;
                r_left  <= w_len;
                r_oaddr <= Out_Addr;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
            end
            if (r_state == S_READ) begin
                r_addr <= r_addr + 1'b1;
                r_left <= r_left - 1'b1;
            end
            if (r_vld) begin
                r_acc <= w_acc_sum[Data_Width_Out-1:0];
                if (w_acc_sum[Data_Width_Out+1:Data_Width_Out] != '0)
                    r_ovf <= 1'b1;
            end
            if (r_state == S_WRITE) r_result <= r_acc;
        end
    end

    assign Overflow = r_ovf;
    assign Result   = r_result;
endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl with behavioural SRAMs and a
// plain-arithmetic reference of the dot product.
module tb_dot_product_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic        Clear_Req;
    logic [3:0]  Base_Addr;
    logic [4:0]  Len;
    logic [3:0]  Out_Addr;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic [15:0] Result;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] in0_mem [16];
    logic [15:0] in1_mem [16];
    logic [15:0] out_mem [16];
    logic [15:0] rd0 = '0;
    logic [15:0] rd1 = '0;

    dot_product_ctrl_if bus ();

    dot_product_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Clear_Req (Clear_Req),
        .Base_Addr (Base_Addr),
        .Len       (Len),
        .Out_Addr  (Out_Addr),
        .Busy      (Busy),
        .Done      (Done),
        .Overflow  (Overflow),
        .Result    (Result),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural SRAMs: one-cycle read latency, write on the edge.
    always @(posedge clk) begin
        if (bus.In_Chip_Select && bus.In_En_Read) begin
            rd0 <= in0_mem[bus.In_Read_Addr];
            rd1 <= in1_mem[bus.In_Read_Addr];
        end
        if (bus.Out_Chip_Select && bus.Out_En_Write)
            out_mem[bus.Out_Write_Addr] <= bus.Out_Write_Data[15:0];
    end
    assign bus.In_Read_Data0 = rd0;
    assign bus.In_Read_Data1 = rd1;

    function automatic logic [15:0] pack2(input int l0, input int l1);
        return {8'(l1), 8'(l0)};
    endfunction

    task automatic fill(input int a0, input int a1, input int b0, input int b1);
        for (int i = 0; i < 16; i++) begin
            in0_mem[i] = pack2(a0, a1);
            in1_mem[i] = pack2(b0, b1);
        end
    endtask

    task automatic run_op(input string nm, input logic [3:0] base,
                          input logic [4:0] len, input logic [3:0] oaddr,
                          input int inject);
        longint sum;
        int L, exp_done, done_cyc, rd_n, wr_n, wr_cyc, clr_n;
        logic [15:0] a, b, exp_res;
        logic exp_ovf;
        logic [3:0] wr_addr, ea;
        logic [31:0] wr_data;
        L = (len > 5'd16) ? 16 : int'(len);
        sum = 0;
        for (int i = 0; i < L; i++) begin
            a = in0_mem[(int'(base) + i) % 16];
            b = in1_mem[(int'(base) + i) % 16];
            sum += longint'(a[7:0]) * longint'(b[7:0]);
            sum += longint'(a[15:8]) * longint'(b[15:8]);
        end
        exp_res  = 16'(sum % 65536);
        exp_ovf  = (sum > 65535);
        exp_done = (L == 0) ? 2 : L + 3;
        done_cyc = -1; rd_n = 0; wr_n = 0; wr_cyc = -1; clr_n = 0;
        wr_addr = '0; wr_data = '0;
        @(negedge clk);
        Start = 1'b1; Base_Addr = base; Len = len; Out_Addr = oaddr;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            Start = 1'b0; Clear_Req = 1'b0;
            if (bus.In_Chip_Select && bus.In_En_Read) begin
                ea = 4'((int'(base) + rd_n) % 16);
                n_cmp++;
                if (bus.In_Read_Addr !== ea) begin
                    n_err++;
                    $display("FAIL %s rd_addr[%0d]: got %0d want %0d",
                             nm, rd_n, bus.In_Read_Addr, ea);
                end
                rd_n++;
            end
            if (bus.Mem_Clear) clr_n++;
            if (bus.Out_Chip_Select && bus.Out_En_Write) begin
                wr_n++; wr_cyc = cyc;
                wr_addr = bus.Out_Write_Addr; wr_data = bus.Out_Write_Data;
            end
            if (Done) begin
                done_cyc = cyc;
                n_cmp++;
                if (Result !== exp_res || Overflow !== exp_ovf) begin
                    n_err++;
                    $display("FAIL %s result: got %0d ovf %0d want %0d ovf %0d",
                             nm, Result, Overflow, exp_res, exp_ovf);
                end
            end
            if (cyc == inject) begin
                Start = 1'b1; Clear_Req = 1'b1;
                Base_Addr = ~base; Len = 5'd3; Out_Addr = ~oaddr;
            end
        end
        n_cmp++;
        if (done_cyc != exp_done) begin
            n_err++;
            $display("FAIL %s done_cycle: got %0d want %0d", nm, done_cyc, exp_done);
        end
        n_cmp++;
        if (rd_n != L || wr_n != 1 || clr_n != 0 || wr_cyc != exp_done - 1) begin
            n_err++;
            $display("FAIL %s counts: reads %0d writes %0d clears %0d wcyc %0d want %0d 1 0 %0d",
                     nm, rd_n, wr_n, clr_n, wr_cyc, L, exp_done - 1);
        end
        n_cmp++;
        if (wr_addr !== oaddr || wr_data !== {16'h0, exp_res}) begin
            n_err++;
            $display("FAIL %s write: got @%0d %h want @%0d %h",
                     nm, wr_addr, wr_data, oaddr, {16'h0, exp_res});
        end
        @(negedge clk);
        Start = 1'b0; Clear_Req = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0 || out_mem[oaddr] !== exp_res) begin
            n_err++;
            $display("FAIL %s after: busy %0d mem %0d want 0 %0d",
                     nm, Busy, out_mem[oaddr], exp_res);
        end
        if (inject > 0) begin
            repeat (3) @(negedge clk);
            n_cmp++;
            if (Busy !== 1'b0 || bus.Mem_Clear !== 1'b0) begin
                n_err++;
                $display("FAIL %s ignored_start: busy %0d clr %0d want 0 0",
                         nm, Busy, bus.Mem_Clear);
            end
        end
    endtask

    task automatic check_idle_outputs(input string nm, input logic [15:0] exp_res);
        n_cmp++;
        if ({Busy, Done, Overflow, bus.Mem_Clear, bus.In_Chip_Select,
             bus.In_En_Read, bus.Out_Chip_Select, bus.Out_En_Write} !== 8'h0
            || bus.In_Read_Addr !== 4'h0 || bus.Out_Write_Addr !== 4'h0
            || bus.Out_Write_Data !== 32'h0 || Result !== exp_res) begin
            n_err++;
            $display("FAIL %s outputs: busy %0d done %0d ovf %0d clr %0d ics %0d ocs %0d res %0d want all 0 res %0d",
                     nm, Busy, Done, Overflow, bus.Mem_Clear, bus.In_Chip_Select,
                     bus.Out_Chip_Select, Result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Clear_Req = 1'b0;
        Base_Addr = '0; Len = '0; Out_Addr = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 16'h0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset", 16'h0);
    endtask

    task automatic test_single();
        fill(0, 0, 0, 0);
        in0_mem[0] = pack2(2, 3);
        in1_mem[0] = pack2(4, 5);
        run_op("single", 4'd0, 5'd1, 4'd10, 0);
    endtask

    task automatic test_wrap();
        fill(1, 1, 2, 3);
        run_op("wrap", 4'd4, 5'd16, 4'd3, 0);
    endtask

    task automatic test_len0();
        run_op("len0", 4'd7, 5'd0, 4'd5, 0);
    endtask

    task automatic test_overflow();
        fill(255, 255, 255, 255);
        run_op("overflow", 4'd0, 5'd16, 4'd1, 0);
        n_cmp++;
        if (Result !== 16'hC020 || Overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_const: got %h ovf %0d want c020 ovf 1", Result, Overflow);
        end
    endtask

    task automatic test_clear_priority();
        int clr_n, clr_first, rd_n, dn_n;
        clr_n = 0; clr_first = -1; rd_n = 0; dn_n = 0;
        @(negedge clk);
        Start = 1'b1; Clear_Req = 1'b1; Len = 5'd3; Base_Addr = 4'd0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            Start = 1'b0; Clear_Req = 1'b0;
            if (bus.Mem_Clear) begin
                clr_n++;
                if (clr_first < 0) clr_first = cyc;
            end
            if (bus.In_En_Read || bus.In_Chip_Select) rd_n++;
            if (Done) dn_n++;
        end
        n_cmp++;
        if (clr_n != 1 || clr_first != 1 || rd_n != 0 || dn_n != 0) begin
            n_err++;
            $display("FAIL clear_prio: clears %0d at %0d reads %0d dones %0d want 1 at 1 0 0",
                     clr_n, clr_first, rd_n, dn_n);
        end
        fill(1, 2, 3, 4);
        run_op("start_in_read", 4'd9, 5'd8, 4'd12, 3);
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        fill(7, 9, 11, 13);
        @(negedge clk);
        Start = 1'b1; Base_Addr = 4'd2; Len = 5'd10; Out_Addr = 4'd6;
        repeat (3) begin
            @(negedge clk);
            Start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset_mid", 16'h0);
        repeat (15) begin
            @(negedge clk);
            if (bus.Out_En_Write || bus.Out_Chip_Select || Done || Busy) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: active cycles %0d want 0", bad);
        end
        run_op("after_reset", 4'd2, 5'd10, 4'd6, 0);
    endtask

    task automatic test_random();
        string nm;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) begin
                in0_mem[i] = 16'($urandom);
                in1_mem[i] = 16'($urandom);
            end
            nm = $sformatf("rand%0d", t);
            run_op(nm, 4'($urandom), 5'($urandom_range(0, 20)),
                   4'($urandom), 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_len0();
        test_overflow();
        test_clear_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
